// File: rtl/vga_sink.sv
// vga_sink: locks to incoming VGA sync timing, measures line/frame totals and signs each frame's active pixels.
// Signature path is built only when VGA_SINK_SIG_EN is defined; otherwise frame_sig reads 0.
module vga_sink #(
  parameter int PIX_DIV  = 2,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 1000000
) (
  input  logic        CLK1_50,
  input  logic        RST_N,
  input  logic [2:0]  VGA_R,
  input  logic [2:0]  VGA_G,
  input  logic [2:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  output logic        locked,
  output logic        frame_done,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [15:0] frame_sig,
  output logic        err
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {SEEK, MEAS, LOCK} state_t;
  state_t state_q, state_d;
  logic hs1_q, hs2_q, vs1_q, vs2_q, hs_rise, hs_fall, vs_fall, pix, match, tmo;
  logic [DW-1:0] div_q, div_d;
  logic [11:0] h_per_q, h_per_d, h_inc, line_len_q, line_len_d, ref_h_q, ref_h_d, h_total_q, h_total_d;
  logic [10:0] v_per_q, v_per_d, v_inc, ref_v_q, ref_v_d, v_total_q, v_total_d;
  logic [WW-1:0] wd_q, wd_d;
  logic frame_done_q, frame_done_d, err_q, err_d;
  assign hs_rise = hs1_q & ~hs2_q;
  assign hs_fall = ~hs1_q & hs2_q;
  assign vs_fall = ~vs1_q & vs2_q;
  assign pix = div_q == '0;
  assign div_d = hs_rise || div_q == DW'(PIX_DIV - 1) ? '0 : div_q + DW'(1);
  assign h_inc = h_per_q + 12'(pix && h_per_q != '1);
  assign h_per_d = hs_fall ? '0 : h_inc;
  assign line_len_d = hs_fall ? h_inc : line_len_q;
  // an HS fall coincident with VS fall belongs to the frame that is ending
  assign v_inc = v_per_q + 11'(hs_fall && v_per_q != '1);
  assign v_per_d = vs_fall ? '0 : v_inc;
  assign match = line_len_d == ref_h_q && v_inc == ref_v_q;
  assign tmo = state_q != SEEK && !vs_fall && wd_q == WW'(TIMEOUT - 1);
  assign wd_d = vs_fall || tmo || state_q == SEEK ? '0 : wd_q + WW'(1);
  assign locked = state_q == LOCK;
  assign frame_done = frame_done_q;
  assign h_total = h_total_q;
  assign v_total = v_total_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    ref_h_d = ref_h_q;
    ref_v_d = ref_v_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    frame_done_d = 1'b0;
    err_d = err_q;
    if (tmo) begin
      state_d = SEEK;
      err_d = 1'b1;
    end else if (vs_fall)
      case (state_q)
        SEEK: state_d = MEAS;
        MEAS: begin
          state_d = LOCK;
          ref_h_d = line_len_d;
          ref_v_d = v_inc;
        end
        default:
          if (match) begin
            frame_done_d = 1'b1;
            h_total_d = line_len_d;
            v_total_d = v_inc;
          end else begin
            state_d = MEAS;
            err_d = 1'b1;
          end
      endcase
  end
  always_ff @(posedge CLK1_50)
    if (!RST_N) begin
      state_q <= SEEK;
      {hs1_q, hs2_q, vs1_q, vs2_q} <= '1;
      div_q <= '0;
      h_per_q <= '0;
      line_len_q <= '0;
      ref_h_q <= '0;
      h_total_q <= '0;
      v_per_q <= '0;
      ref_v_q <= '0;
      v_total_q <= '0;
      wd_q <= '0;
      frame_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {hs1_q, hs2_q, vs1_q, vs2_q} <= {VGA_HS, hs1_q, VGA_VS, vs1_q};
      div_q <= div_d;
      h_per_q <= h_per_d;
      line_len_q <= line_len_d;
      ref_h_q <= ref_h_d;
      h_total_q <= h_total_d;
      v_per_q <= v_per_d;
      ref_v_q <= ref_v_d;
      v_total_q <= v_total_d;
      wd_q <= wd_d;
      frame_done_q <= frame_done_d;
      err_q <= err_d;
    end
`ifdef VGA_SINK_SIG_EN
  logic [8:0] rgb1_q;
  logic [11:0] h_cnt_q;
  logic [10:0] v_cnt_q;
  logic [15:0] sig_q, sig_d, frame_sig_q;
  logic vs_rise, act;
  assign vs_rise = vs1_q & ~vs2_q;
  assign act = pix && hs1_q && vs1_q && h_cnt_q >= 12'(H_BP) && h_cnt_q < 12'(H_BP + H_ACTIVE) &&
               v_cnt_q >= 11'(V_BP) && v_cnt_q < 11'(V_BP + V_ACTIVE);
  assign sig_d = act ? {sig_q[14:0], sig_q[15]} ^ {7'b0, rgb1_q} : sig_q;
  assign frame_sig = frame_sig_q;
  always_ff @(posedge CLK1_50)
    if (!RST_N) begin
      rgb1_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      sig_q <= '0;
      frame_sig_q <= '0;
    end else begin
      rgb1_q <= {VGA_R, VGA_G, VGA_B};
      h_cnt_q <= hs_rise ? '0 : h_cnt_q + 12'(pix && h_cnt_q != '1);
      v_cnt_q <= vs_rise ? '0 : v_cnt_q + 11'(hs_fall && v_cnt_q != '1);
      sig_q <= vs_fall ? '0 : sig_d;
      if (frame_done_d) frame_sig_q <= sig_d;
    end
`else
  logic unused_rgb;
  assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
  assign frame_sig = '0;
`endif
endmodule
